// File: rtl/period_meter.sv
// period_meter: synchronizes SIG_IN, times the CLK-cycle gap between
// consecutive rising edges, and strobes each finished interval on TN/SAMPLE.
// N counts issued samples (saturating at DEPTH), OVERFLOW is sticky on a
// saturated interval. Optional glitch filter: PERIOD_METER_GLITCH_FILTER_EN.
module period_meter #(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 14,
    parameter int FILTER_LEN  = 3
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             ENABLE,
    input  logic             SIG_IN,
    output logic [WIDTH-1:0] TN,
    output logic             SAMPLE,
    output logic [3:0]       N,
    output logic             OVERFLOW
);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [3:0]       DEPTH_N = 4'(DEPTH);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic [SYNC_STAGES-1:0] vld_pipe;
    logic                   sync_lvl;
    logic                   sync_ok;
    logic                   edge_lvl;
    logic                   prev_lvl;
    logic                   rise;
    logic                   rise_q;

    state_t                 state, state_d;
    logic [WIDTH-1:0]       cnt, cnt_d;
    logic [WIDTH-1:0]       tn_d;
    logic                   sample_d;
    logic [3:0]             n_d;
    logic                   ovf_d;

    // Metastability chain; vld_pipe marks when the chain holds real samples
    // rather than reset zeros, so a high input at reset is not seen as an edge.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sync_pipe <= '0;
            vld_pipe  <= '0;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], SIG_IN};
            vld_pipe  <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_lvl = sync_pipe[SYNC_STAGES-1];
    assign sync_ok  = vld_pipe[SYNC_STAGES-1];

`ifdef PERIOD_METER_GLITCH_FILTER_EN
    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [FCW-1:0] filt_cnt;
    logic           filt_lvl;

    // Level follows the synchronized input only after FILTER_LEN stable cycles;
    // starts high so an input already high at reset cannot create an edge.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            filt_cnt <= '0;
            filt_lvl <= 1'b1;
        end else if (!sync_ok || (sync_lvl == filt_lvl)) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
            filt_lvl <= sync_lvl;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    assign edge_lvl = filt_lvl;
`else
    assign edge_lvl = sync_lvl;
`endif

    // Edge detect; prev is parked high until the chain is primed.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            prev_lvl <= 1'b1;
            rise_q   <= 1'b0;
        end else begin
            prev_lvl <= sync_ok ? edge_lvl : 1'b1;
            rise_q   <= rise;
        end
    end

    assign rise = edge_lvl & ~prev_lvl;

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state    <= IDLE;
            cnt      <= '0;
            TN       <= '0;
            SAMPLE   <= 1'b0;
            N        <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            TN       <= tn_d;
            SAMPLE   <= sample_d;
            N        <= n_d;
            OVERFLOW <= ovf_d;
        end
    end

    // Next state: disable overrides everything, including a coincident rise.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        tn_d     = TN;
        sample_d = 1'b0;
        n_d      = N;
        ovf_d    = OVERFLOW;
        if (!ENABLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            n_d     = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = '0;
                    n_d     = '0;
                    ovf_d   = 1'b0;
                end
                ARM: begin
                    if (rise_q) begin
                        cnt_d   = CNT_ONE;
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise_q) begin
                        tn_d     = cnt;
                        sample_d = 1'b1;
                        cnt_d    = CNT_ONE;
                        if (N != DEPTH_N) n_d = N + 4'd1;
                        if (cnt == CNT_MAX) ovf_d = 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt_d = cnt + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
